// File: rtl/axi_pkg.sv
// Shared types for the AXI write arbiter: FSM state encoding,
// AXI field widths and the master index width.
package axi_pkg;

    typedef enum logic [1:0] {
        WARB_IDLE,
        WARB_AW,
        WARB_W,
        WARB_B
    } warb_state_e;

    localparam int AXI_LEN_W   = 4;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;
    localparam int WARB_IDX_W  = 2;

    function automatic logic [WARB_IDX_W-1:0] warb_idx(input logic [3:0] oh);
        logic [WARB_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = WARB_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/warb_picker.sv
// One-hot request picker. AXI_WARB_RR_EN: round-robin from ptr,
// otherwise fixed priority with the lowest index winning.
module warb_picker
    import axi_pkg::*;
#(
    parameter int NUM_M = 2
) (
    input  logic [NUM_M-1:0]      req,
`ifdef AXI_WARB_RR_EN
    input  logic [WARB_IDX_W-1:0] ptr,
`endif
    output logic [NUM_M-1:0]      gnt
);

`ifdef AXI_WARB_RR_EN
    always_comb begin
        int k;
        gnt = '0;
        k   = 0;
        // Walk backwards so the candidate closest to ptr wins.
        for (int i = NUM_M - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NUM_M;
            if (req[k]) gnt = NUM_M'(1) << k;
        end
    end
`else
    always_comb begin
        gnt = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req[i]) gnt = NUM_M'(1) << i;
        end
    end
`endif

endmodule

// File: rtl/axi_write_arbiter.sv
// Burst-locked AXI write-path arbiter (AW/W/B) for NUM_M masters.
// AXI_WARB_RR_EN selects round-robin instead of fixed priority.
module axi_write_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int AW_W  = ID_W + ADDR_W + 15,
    localparam int W_W   = DATA_W + DATA_W / 8 + 1,
    localparam int B_W   = ID_W + AXI_RESP_W
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [NUM_M-1:0]             m_awvalid,
    output logic [NUM_M-1:0]             m_awready,
    input  logic [NUM_M*AW_W-1:0]        m_aw,
    input  logic [NUM_M-1:0]             m_wvalid,
    output logic [NUM_M-1:0]             m_wready,
    input  logic [NUM_M*W_W-1:0]         m_w,
    output logic [NUM_M-1:0]             m_bvalid,
    input  logic [NUM_M-1:0]             m_bready,
    output logic [B_W-1:0]               m_b,
    output logic                         s_awvalid,
    input  logic                         s_awready,
    output logic [AW_W+WARB_IDX_W-1:0]   s_aw,
    output logic                         s_wvalid,
    input  logic                         s_wready,
    output logic [W_W-1:0]               s_w,
    input  logic                         s_bvalid,
    output logic                         s_bready,
    input  logic [B_W+WARB_IDX_W-1:0]    s_b,
    output logic [NUM_M-1:0]             grant
);

    warb_state_e             state_q;
    logic [WARB_IDX_W-1:0]   gidx_q;
    logic                    err_q;
    logic [NUM_M-1:0]        pick;
    logic [WARB_IDX_W-1:0]   pick_idx;
    logic [AW_W-1:0]         aw_sel;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    wlast;

`ifdef AXI_WARB_RR_EN
    logic [WARB_IDX_W-1:0]   ptr_q;
    logic [WARB_IDX_W-1:0]   ptr_nxt;

    assign ptr_nxt = WARB_IDX_W'((int'(pick_idx) + 1) % NUM_M);

    warb_picker #(.NUM_M(NUM_M)) u_pick (
        .req (m_awvalid),
        .ptr (ptr_q),
        .gnt (pick)
    );
`else
    warb_picker #(.NUM_M(NUM_M)) u_pick (
        .req (m_awvalid),
        .gnt (pick)
    );
`endif

    assign pick_idx = warb_idx(4'(pick));

    // Data muxes keyed by the one-hot grant; all zero while idle.
    always_comb begin
        aw_sel = '0;
        s_w    = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant[i]) begin
                aw_sel = m_aw[i*AW_W +: AW_W];
                s_w    = m_w[i*W_W +: W_W];
            end
        end
    end

    assign s_aw  = {gidx_q, aw_sel};
    assign m_b   = s_b[B_W-1:0];
    assign wlast = s_w[0];
    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign b_hs  = s_bvalid & s_bready;

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        unique case (state_q)
            WARB_AW: begin
                s_awvalid = |(m_awvalid & grant);
                m_awready = grant & {NUM_M{s_awready}};
                s_wvalid  = |(m_wvalid & grant);
                m_wready  = grant & {NUM_M{s_wready}};
            end
            WARB_W: begin
                s_wvalid  = |(m_wvalid & grant);
                m_wready  = grant & {NUM_M{s_wready}};
            end
            WARB_B: begin
                s_bready  = |(m_bready & grant);
                m_bvalid  = grant & {NUM_M{s_bvalid}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= WARB_IDLE;
            grant   <= '0;
            gidx_q  <= '0;
            err_q   <= 1'b0;
`ifdef AXI_WARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                WARB_IDLE: begin
                    if (|m_awvalid) begin
                        grant   <= pick;
                        gidx_q  <= pick_idx;
                        state_q <= WARB_AW;
`ifdef AXI_WARB_RR_EN
                        ptr_q   <= ptr_nxt;
`endif
                    end
                end
                WARB_AW: begin
                    if (aw_hs) begin
                        state_q <= (w_hs && wlast) ? WARB_B : WARB_W;
                    end
                end
                WARB_W: begin
                    if (w_hs && wlast) state_q <= WARB_B;
                end
                WARB_B: begin
                    if (b_hs) begin
                        grant   <= '0;
                        state_q <= WARB_IDLE;
                        if (s_b[B_W+WARB_IDX_W-1:B_W] != gidx_q) err_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    always @(posedge ACLK) begin
        if (ARESETn) begin
            if (state_q == WARB_AW) assert (|(m_awvalid & grant));
            assert (!err_q);
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed scoreboard bench for axi_write_arbiter; follows
// AXI_WARB_RR_EN for the expected arbitration order.
module tb_axi_write_arbiter;

    localparam int NUM_M  = 2;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int AW_W   = ID_W + ADDR_W + 15;
    localparam int SAW_W  = AW_W + 2;
    localparam int W_W    = DATA_W + DATA_W / 8 + 1;
    localparam int B_W    = ID_W + 2;

    logic                  ACLK = 1'b0;
    logic                  ARESETn = 1'b0;
    logic [NUM_M-1:0]      m_awvalid;
    logic [NUM_M-1:0]      m_awready;
    logic [NUM_M*AW_W-1:0] m_aw;
    logic [NUM_M-1:0]      m_wvalid;
    logic [NUM_M-1:0]      m_wready;
    logic [NUM_M*W_W-1:0]  m_w;
    logic [NUM_M-1:0]      m_bvalid;
    logic [NUM_M-1:0]      m_bready;
    logic [B_W-1:0]        m_b;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [SAW_W-1:0]      s_aw;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [W_W-1:0]        s_w;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [B_W+1:0]        s_b;
    logic [NUM_M-1:0]      grant;

    int n_chk  = 0;
    int n_fail = 0;

    logic [SAW_W-1:0] q_aw[$];
    logic [W_W-1:0]   q_w[$];
    logic [B_W-1:0]   q_b[$];

    axi_write_arbiter #(
        .NUM_M(NUM_M), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b),
        .grant(grant)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW_W-1:0] aw_word(input int m, input int id, input int len);
        logic [31:0] a;
        a = 32'h4000_0000 + 32'(m * 256 + id * 16);
        return {4'(id), a, 4'(len), 3'd2, 2'd1, 6'd0};
    endfunction

    function automatic logic [W_W-1:0] w_word(input int m, input int id, input int b, input bit last);
        logic [31:0] d;
        d = 32'hA000_0000 | 32'(m << 24) | 32'(id << 16) | 32'(b);
        return {d, 4'hF, last};
    endfunction

    task automatic set_aw(input int m, input int id, input int len);
        m_aw[m*AW_W +: AW_W] = aw_word(m, id, len);
        m_awvalid[m] = 1'b1;
    endtask

    task automatic set_w(input int m, input int id, input int b, input bit last);
        m_w[m*W_W +: W_W] = w_word(m, id, b, last);
        m_wvalid[m] = 1'b1;
    endtask

    // Runs one burst for master m; entered and left just after a rising edge.
    task automatic serve(input int m, input int id, input int len, input int bdly,
                         input bit again, input int rst_beat);
        int beat;
        int bw;
        int t;
        bit w_done;
        bit b_done;
        bit gchk;
        bit awh;
        bit wh;
        logic [NUM_M-1:0] oh;
        beat = 0; bw = 0; t = 0;
        w_done = 0; b_done = 0; gchk = 0;
        oh = NUM_M'(1) << m;
        q_aw.push_back({2'(m), aw_word(m, id, len)});
        for (int b = 0; b <= len; b++) q_w.push_back(w_word(m, id, b, b == len));
        q_b.push_back({4'(id), 2'(id)});
        set_aw(m, id, len);
        set_w(m, id, 0, len == 0);
        while (!b_done && t < 100) begin
            t++;
            awh = 0; wh = 0;
            if (rst_beat >= 0 && beat == rst_beat) begin
                ARESETn = 1'b0;
                #1;
                chk("rst_grant", grant, 0);
                chk("rst_m_wready", m_wready, 0);
                chk("rst_m_awready", m_awready, 0);
                chk("rst_s_wvalid", s_wvalid, 0);
                chk("rst_s_awvalid", s_awvalid, 0);
                m_awvalid = '0; m_wvalid = '0; m_bready = '0; s_bvalid = 1'b0;
                q_aw.delete(); q_w.delete(); q_b.delete();
                @(posedge ACLK); #1;
                ARESETn = 1'b1;
                return;
            end
            s_bvalid = w_done;
            s_b = {2'(m), 4'(id), 2'(id)};
            m_bready[m] = w_done && (bw >= bdly);
            #1;
            if (grant != 0 && !gchk) begin
                chk("grant", grant, oh);
                gchk = 1;
            end
            chk("awready_other", m_awready & ~oh, 0);
            chk("wready_other", m_wready & ~oh, 0);
            if (s_awvalid && s_awready) begin
                awh = 1;
                if (q_aw.size() == 0) chk("aw_extra", 1, 0);
                else chk("s_aw", s_aw, q_aw.pop_front());
            end
            if (s_wvalid && s_wready) begin
                wh = 1;
                if (q_w.size() == 0) chk("w_extra", 1, 0);
                else chk("s_w", s_w, q_w.pop_front());
            end
            if (w_done) begin
                chk("grant_held_b", grant, oh);
                chk("m_bvalid", m_bvalid, oh);
                chk("s_bready", s_bready, m_bready[m]);
                if (m_bready[m]) begin
                    chk("m_b", m_b, q_b.pop_front());
                    b_done = 1;
                end else begin
                    bw++;
                end
            end
            @(posedge ACLK); #1;
            if (awh) m_awvalid[m] = again;
            if (wh) begin
                if (beat == len) begin
                    w_done = 1;
                    m_wvalid[m] = 1'b0;
                end else begin
                    beat++;
                    set_w(m, id, beat, beat == len);
                end
            end
        end
        chk("burst_done", b_done, 1);
        s_bvalid = 1'b0;
        m_bready = '0;
        #1;
        chk("bubble_grant", grant, 0);
        chk("bubble_bvalid", m_bvalid, 0);
        @(posedge ACLK); #1;
    endtask

    initial begin
        m_aw = '0; m_w = '0; s_b = '0;
        s_awready = 1'b1; s_wready = 1'b1;
        m_awvalid = '1; m_wvalid = '1; m_bready = '1; s_bvalid = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        chk("reset_grant", grant, 0);
        chk("reset_m_awready", m_awready, 0);
        chk("reset_m_wready", m_wready, 0);
        chk("reset_m_bvalid", m_bvalid, 0);
        chk("reset_s_awvalid", s_awvalid, 0);
        chk("reset_s_wvalid", s_wvalid, 0);
        chk("reset_s_bready", s_bready, 0);
        m_awvalid = '0; m_wvalid = '0; m_bready = '0; s_bvalid = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        serve(0, 3, 3, 0, 0, -1);

        serve(1, 2, 0, 0, 0, -1);

        set_aw(1, 5, 1);
`ifdef AXI_WARB_RR_EN
        serve(0, 1, 1, 0, 1, -1);
        serve(1, 5, 1, 0, 0, -1);
        serve(0, 1, 1, 0, 0, -1);
`else
        serve(0, 1, 1, 0, 1, -1);
        serve(0, 1, 1, 0, 0, -1);
        serve(1, 5, 1, 0, 0, -1);
`endif

        set_w(1, 9, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("early_m_wready", m_wready, 0);
            chk("early_s_wvalid", s_wvalid, 0);
            @(posedge ACLK); #1;
        end
        serve(1, 9, 2, 0, 0, -1);

        set_aw(1, 6, 0);
        serve(0, 5, 2, 5, 0, -1);
        serve(1, 6, 0, 0, 0, -1);

        serve(0, 7, 3, 0, 0, 2);
        #1;
        chk("post_rst_grant", grant, 0);
        @(posedge ACLK); #1;
        serve(0, 4, 1, 0, 0, -1);

        chk("queues_empty", q_aw.size() + q_w.size() + q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
